// File: rtl/config_pkg.sv
// config_pkg: endpoint consumer configuration shared by the USB device core slice.
package config_pkg;
  typedef enum logic [1:0] {
    LB_MODE_ECHO   = 2'd0,
    LB_MODE_SINK   = 2'd1,
    LB_MODE_SOURCE = 2'd2,
    LB_MODE_RSVD   = 2'd3
  } ep_lb_mode_t;
endpackage

// File: rtl/usb_ep_loopback_fifo.sv
// ep_lb_fifo: single-channel FWFT FIFO that holds bytes back until a whole packet (or a full buffer) is present.
module ep_lb_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 64
) (
  input  logic             clk48,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             rel
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wp, rp, pkt_cnt;
  logic empty;
  always_comb begin
    full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    empty = wp == rp;
    dout = mem[rp[AW-1:0]];
    rel = !empty && (pkt_cnt != '0 || full);
  end
  always_ff @(posedge clk48)
    if (push) mem[wp[AW-1:0]] <= din;
  always_ff @(posedge clk48)
    if (rst || clr) begin
      wp <= '0;
      rp <= '0;
      pkt_cnt <= '0;
    end else begin
      wp <= wp + (AW+1)'(push);
      rp <= rp + (AW+1)'(pop);
      pkt_cnt <= pkt_cnt + (AW+1)'(push && din[WIDTH-1]) - (AW+1)'(pop && dout[WIDTH-1]);
    end
endmodule

// File: rtl/usb_ep_loopback.sv
// usb_ep_loopback: per-endpoint ECHO/SINK/SOURCE loopback consumer with packet-aware store-and-forward.
module usb_ep_loopback
  import config_pkg::*;
#(
  parameter int EP_COUNT   = 2,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 64,
  parameter int MAX_PACKET = 64
) (
  input  logic                           clk48,
  input  logic                           rst,
  input  logic [2*EP_COUNT-1:0]          mode_i,
  input  logic [DATA_WIDTH*EP_COUNT-1:0] out_data_i,
  input  logic [EP_COUNT-1:0]            out_valid_i,
  input  logic [EP_COUNT-1:0]            out_last_i,
  output logic [EP_COUNT-1:0]            out_ready_o,
  output logic [DATA_WIDTH*EP_COUNT-1:0] in_data_o,
  output logic [EP_COUNT-1:0]            in_valid_o,
  output logic [EP_COUNT-1:0]            in_last_o,
  input  logic [EP_COUNT-1:0]            in_ready_i,
  output logic [16*EP_COUNT-1:0]         sink_count_o
);
  localparam int IW = $clog2(MAX_PACKET + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(MAX_PACKET - 1);
  for (genvar c = 0; c < EP_COUNT; c++) begin : g_ep
    ep_lb_mode_t mode_q, mode_d;
    logic flush, echo, src, full, rel, push, pop, rdy, vld, lst;
    logic [DATA_WIDTH:0] head;
    logic [DATA_WIDTH-1:0] pat, dat;
    logic [IW-1:0] idx;
    logic [15:0] sink_cnt;
    assign mode_d = ep_lb_mode_t'(mode_i[2*c +: 2]);
    // a pending mode change stalls both sides for the one cycle it takes to clear state
    always_comb begin
      flush = mode_d != mode_q;
      echo = mode_q == LB_MODE_ECHO;
      src = mode_q == LB_MODE_SOURCE;
      rdy = !flush && (!echo || !full);
      vld = !flush && (echo ? rel : src);
      dat = !vld ? '0 : echo ? head[DATA_WIDTH-1:0] : pat;
      lst = vld && (echo ? head[DATA_WIDTH] : idx == LAST_IDX);
      push = echo && out_valid_i[c] && rdy;
      pop = echo && vld && in_ready_i[c];
    end
    ep_lb_fifo #(.WIDTH(DATA_WIDTH + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk48(clk48),
      .rst(rst),
      .clr(flush),
      .push(push),
      .pop(pop),
      .din({out_last_i[c], out_data_i[c*DATA_WIDTH +: DATA_WIDTH]}),
      .dout(head),
      .full(full),
      .rel(rel)
    );
    always_ff @(posedge clk48)
      if (rst || flush) begin
        mode_q <= rst ? LB_MODE_ECHO : mode_d;
        pat <= '0;
        idx <= '0;
        sink_cnt <= '0;
      end else begin
        if (src && in_ready_i[c]) begin
          pat <= pat + DATA_WIDTH'(1);
          idx <= idx == LAST_IDX ? '0 : idx + IW'(1);
        end
        if (!echo && !src && out_valid_i[c]) sink_cnt <= sink_cnt + 16'd1;
      end
    assign out_ready_o[c] = rdy;
    assign in_valid_o[c] = vld;
    assign in_last_o[c] = lst;
    assign in_data_o[c*DATA_WIDTH +: DATA_WIDTH] = dat;
    assign sink_count_o[16*c +: 16] = sink_cnt;
  end
endmodule
